// File: rtl/jtag_tap_pkg.sv
// Purpose: shared TAP state encoding for the oversampled JTAG TAP family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_tap_pkg;

    localparam int TAP_STATE_W = 4;

    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_TLR   = 4'hF,
        TAP_RTI   = 4'hC,
        TAP_SELDR = 4'h7,
        TAP_CAPDR = 4'h6,
        TAP_SHDR  = 4'h2,
        TAP_EX1DR = 4'h1,
        TAP_PADR  = 4'h3,
        TAP_EX2DR = 4'h0,
        TAP_UPDR  = 4'h5,
        TAP_SELIR = 4'h4,
        TAP_CAPIR = 4'hE,
        TAP_SHIR  = 4'hA,
        TAP_EX1IR = 4'h9,
        TAP_PAIR  = 4'hB,
        TAP_EX2IR = 4'h8,
        TAP_UPIR  = 4'hD
    } tap_state_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// Purpose: IEEE 1149.1 TAP next-state function, shared across TAP variants.
// Latency: purely combinational.
// Backpressure: none; caller decides when to commit next_state.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  tap_state_e state,
    input  logic       tms,
    output tap_state_e next_state
);

    // Standard 16-state TAP transition table, selected by TMS.
    always_comb begin
        next_state = TAP_TLR;
        case (state)
            TAP_TLR:   next_state = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   next_state = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: next_state = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: next_state = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  next_state = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: next_state = tms ? TAP_UPDR  : TAP_PADR;
            TAP_PADR:  next_state = tms ? TAP_EX2DR : TAP_PADR;
            TAP_EX2DR: next_state = tms ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  next_state = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: next_state = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: next_state = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  next_state = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: next_state = tms ? TAP_UPIR  : TAP_PAIR;
            TAP_PAIR:  next_state = tms ? TAP_EX2IR : TAP_PAIR;
            TAP_EX2IR: next_state = tms ? TAP_UPIR  : TAP_SHIR;
            TAP_UPIR:  next_state = tms ? TAP_SELDR : TAP_RTI;
            default:   next_state = TAP_TLR;
        endcase
    end

endmodule

// File: rtl/jtag_os_tap.sv
// Purpose: oversampled JTAG TAP (IR/BYPASS/IDCODE + user-DR strobes) in the clk domain; optional TRST via JTAG_OS_TAP_TRST_EN.
// Latency: 1 clk from a synchronized TCK edge to registered state/TDO/strobes (pad-to-effect 4 clk incl. sync).
// Backpressure: none; the host paces everything through TCK, which must be at most clk/4.
module jtag_os_tap
    import jtag_tap_pkg::*;
#(
    parameter int              IR_W      = 4,
    parameter logic [31:0]     IDCODE    = 32'h0000_0001,
    parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(1),
    parameter logic [IR_W-1:0] OP_BYPASS = '1
) (
    input  logic                   clk,
    input  logic                   rst_p,
`ifdef JTAG_OS_TAP_TRST_EN
    input  logic                   trst_n_s,
`endif
    input  logic                   tck_s,
    input  logic                   tms_s,
    input  logic                   tdi_s,
    output logic                   tdo,
    output logic                   tdo_oe,
    output logic [TAP_STATE_W-1:0] state,
    output logic [IR_W-1:0]        ir,
    output logic                   user_sel,
    output logic                   capture_dr,
    output logic                   shift_dr,
    output logic                   update_dr,
    output logic                   user_tdi,
    input  logic                   user_tdo
);

    logic            tck_q;
    tap_state_e      state_q, state_d, fsm_next;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [31:0]     id_sh_q, id_sh_d;
    logic            byp_q, byp_d;
    logic            tdo_q, tdo_d;
    logic            tdo_oe_q, tdo_oe_d;
    logic            capture_dr_q, capture_dr_d;
    logic            shift_dr_q, shift_dr_d;
    logic            update_dr_q, update_dr_d;
    logic            user_tdi_q, user_tdi_d;

    logic rise, fall;
    logic sel_id, sel_byp;
    logic dr_lsb;

    assign rise = tck_s & ~tck_q;
    assign fall = ~tck_s & tck_q;

    assign sel_id   = (ir_q == OP_IDCODE);
    assign sel_byp  = (ir_q == OP_BYPASS);
    assign user_sel = ~sel_id & ~sel_byp;

    // LSB of whichever data register the active instruction selects.
    assign dr_lsb = sel_id  ? id_sh_q[0] :
                    sel_byp ? byp_q      : user_tdo;

    jtag_tap_fsm u_fsm (
        .state      (state_q),
        .tms        (tms_s),
        .next_state (fsm_next)
    );

    // Register updates: rise edges advance the FSM and shift; fall edges update IR and drive TDO.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        ir_sh_d      = ir_sh_q;
        id_sh_d      = id_sh_q;
        byp_d        = byp_q;
        tdo_d        = tdo_q;
        tdo_oe_d     = tdo_oe_q;
        capture_dr_d = 1'b0;
        shift_dr_d   = 1'b0;
        update_dr_d  = 1'b0;
        user_tdi_d   = tdi_s;

        if (rise) begin
            state_d = fsm_next;
            case (state_q)
                TAP_CAPIR: ir_sh_d = IR_W'(2'b01);
                TAP_SHIR:  ir_sh_d = {tdi_s, ir_sh_q[IR_W-1:1]};
                TAP_CAPDR: begin
                    if (sel_id)  id_sh_d = IDCODE;
                    if (sel_byp) byp_d   = 1'b0;
                    capture_dr_d = user_sel;
                end
                TAP_SHDR: begin
                    id_sh_d    = {tdi_s, id_sh_q[31:1]};
                    byp_d      = tdi_s;
                    shift_dr_d = user_sel;
                end
                default: ;
            endcase
        end

        if (fall) begin
            // Output enable only survives while the FSM sits in a shift state.
            tdo_oe_d = 1'b0;
            case (state_q)
                TAP_UPIR: ir_d = ir_sh_q;
                TAP_TLR:  ir_d = OP_IDCODE;
                TAP_SHIR: begin
                    tdo_d    = ir_sh_q[0];
                    tdo_oe_d = 1'b1;
                end
                TAP_SHDR: begin
                    tdo_d    = dr_lsb;
                    tdo_oe_d = 1'b1;
                end
                TAP_UPDR: update_dr_d = user_sel;
                default: ;
            endcase
        end

`ifdef JTAG_OS_TAP_TRST_EN
        // Synchronized TRST wins over any TCK activity and holds while low.
        if (!trst_n_s) begin
            state_d  = TAP_TLR;
            ir_d     = OP_IDCODE;
            tdo_oe_d = 1'b0;
        end
`endif
    end

    // State and datapath registers; rst_p clears everything immediately.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            tck_q        <= 1'b0;
            state_q      <= TAP_TLR;
            ir_q         <= OP_IDCODE;
            ir_sh_q      <= '0;
            id_sh_q      <= '0;
            byp_q        <= 1'b0;
            tdo_q        <= 1'b0;
            tdo_oe_q     <= 1'b0;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
            user_tdi_q   <= 1'b0;
        end else begin
            tck_q        <= tck_s;
            state_q      <= state_d;
            ir_q         <= ir_d;
            ir_sh_q      <= ir_sh_d;
            id_sh_q      <= id_sh_d;
            byp_q        <= byp_d;
            tdo_q        <= tdo_d;
            tdo_oe_q     <= tdo_oe_d;
            capture_dr_q <= capture_dr_d;
            shift_dr_q   <= shift_dr_d;
            update_dr_q  <= update_dr_d;
            user_tdi_q   <= user_tdi_d;
        end
    end

    assign state      = state_q;
    assign ir         = ir_q;
    assign tdo        = tdo_q;
    assign tdo_oe     = tdo_oe_q;
    assign capture_dr = capture_dr_q;
    assign shift_dr   = shift_dr_q;
    assign update_dr  = update_dr_q;
    assign user_tdi   = user_tdi_q;

endmodule
